// File: rtl/accu_sched.sv
// rtl/accu_sched.sv - round-robin scheduler sharing one group accumulator among requesters
module accu_sched #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int GROUP    = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 acc_valid_in,
  output logic [7:0]           acc_data_in,
  input  logic                 acc_valid_out,
  input  logic [9:0]           acc_data_out,
  output logic                 res_valid,
  output logic [9:0]           res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy,
  output logic                 err
);

  localparam int BW = $clog2(GROUP + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(GROUP - 1);
  localparam logic [WW-1:0]   LAST_WAIT = WW'(WAIT_MAX - 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] ptr, grant, pick, grant_inc;
  logic            found;
  logic [BW-1:0]   beat_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [7:0]      sel_data;
  logic            sel_valid, hs, last_beat, timeout;

  // Two passes: lowest valid overall, then overridden by lowest valid at/above ptr.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) >= ptr)) pick = ID_W'(i);
    end
  end

  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        req_ready[i] = (state == GRANT);
        sel_data     = req_data[8*i +: 8];
        sel_valid    = req_valid[i];
      end
    end
  end

  assign hs        = (state == GRANT) && sel_valid;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign timeout   = (wait_cnt == LAST_WAIT);
  assign grant_inc = (grant == LAST_ID) ? '0 : grant + 1'b1;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = GRANT;
      GRANT:   if (hs && last_beat) state_nx = WAIT;
      WAIT:    if (acc_valid_out || timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      grant        <= '0;
      beat_cnt     <= '0;
      wait_cnt     <= '0;
      acc_valid_in <= 1'b0;
      acc_data_in  <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_id       <= '0;
      err          <= 1'b0;
    end else begin
      acc_valid_in <= 1'b0;
      res_valid    <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (found) grant <= pick;
          if (acc_valid_out) err <= 1'b1;
        end
        GRANT: begin
          if (hs) begin
            acc_valid_in <= 1'b1;
            acc_data_in  <= sel_data;
            beat_cnt     <= beat_cnt + 1'b1;
          end
          if (hs && last_beat) wait_cnt <= '0;
          if (acc_valid_out) err <= 1'b1;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A result arriving on the timeout cycle still counts as a result.
          if (acc_valid_out) begin
            res_valid <= 1'b1;
            res_data  <= acc_data_out;
            res_id    <= grant;
            ptr       <= grant_inc;
          end else if (timeout) begin
            err <= 1'b1;
            ptr <= grant_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accu_sched.sv
// tb/tb_accu_sched.sv - randomized self-checking bench for accu_sched against a round-robin model
module tb_accu_sched;
  localparam int NR = 4;
  localparam int GROUP = 4;
  localparam int WAIT_MAX = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            acc_valid_in;
  logic [7:0]      acc_data_in;
  logic            acc_valid_out = 1'b0;
  logic [9:0]      acc_data_out = '0;
  logic            res_valid;
  logic [9:0]      res_data;
  logic [1:0]      res_id;
  logic            busy;
  logic            err;

  accu_sched #(.NUM_REQ(NR), .ID_W(2), .GROUP(GROUP), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .acc_valid_in(acc_valid_in), .acc_data_in(acc_data_in), .acc_valid_out(acc_valid_out),
    .acc_data_out(acc_data_out), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int src_q[NR][$];
  int mdl_grp[NR][$];
  int exp_id[$], exp_sum[$];
  int res_id_log[$], res_sum_log[$];
  int beat_log[$], beat_cyc[$];
  int err_cnt = 0, err_cyc = 0, err_busy = 0, entry_cyc = 0;
  int acc_beats = 0, acc_sum = 0, pend = 0, pend_cnt = 0, pend_sum = 0;
  int fixed_lat = 0, multi_ready = 0, ready_bad = 0, model_ptr = 0;
  bit acc_on = 1, rand_lat = 0, rand_stall = 0, spur = 0;
  int hs_cnt[NR], stall_at[NR], stall_left[NR];
  logic [NR-1:0] hs_pending = '0;

  // Sources, accumulator stand-in and output monitor, all stepped on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        for (int i = 0; i < NR; i++) begin
          src_q[i].delete();
          hs_cnt[i] = 0;
          stall_left[i] = 0;
        end
        acc_beats = 0; acc_sum = 0; pend = 0;
        hs_pending = '0; req_valid = '0; acc_valid_out = 1'b0;
      end else begin
        if (acc_valid_in) begin
          beat_log.push_back(int'(acc_data_in));
          beat_cyc.push_back(cyc);
          acc_sum += int'(acc_data_in);
          acc_beats++;
          if (acc_beats == GROUP) begin
            entry_cyc = cyc;
            acc_beats = 0;
            pend = acc_on;
            pend_cnt = rand_lat ? int'($urandom_range(0, 4)) : fixed_lat;
            pend_sum = acc_sum;
            acc_sum = 0;
          end
        end
        if (res_valid) begin
          res_id_log.push_back(int'(res_id));
          res_sum_log.push_back(int'(res_data));
        end
        if (err) begin
          err_cnt++;
          err_cyc = cyc;
          err_busy = int'(busy);
        end
        if ($countones(req_ready) > 1) multi_ready++;
        acc_valid_out = 1'b0;
        if (pend != 0) begin
          if (pend_cnt == 0) begin
            acc_valid_out = 1'b1;
            acc_data_out = 10'(pend_sum);
            pend = 0;
          end else pend_cnt--;
        end
        if (spur) begin
          acc_valid_out = 1'b1;
          acc_data_out = 10'h3ff;
          spur = 0;
        end
        for (int i = 0; i < NR; i++) begin
          int tmp;
          bit v;
          if (hs_pending[i]) begin
            tmp = src_q[i].pop_front();
            hs_cnt[i]++;
          end
          v = (src_q[i].size() > 0);
          if (v && stall_left[i] > 0 && hs_cnt[i] == stall_at[i]) begin
            v = 0;
            stall_left[i]--;
            if (i == 1 && req_ready[0]) ready_bad++;
          end
          if (v && rand_stall && req_ready[i] && $urandom_range(0, 3) == 0) v = 0;
          req_valid[i] = v;
          req_data[8*i +: 8] = v ? 8'(src_q[i][0]) : 8'($urandom);
        end
        #1 hs_pending = req_valid & req_ready;
      end
    end
  end

  task automatic load(input int id, input int a, input int b, input int c, input int d);
    src_q[id].push_back(a); src_q[id].push_back(b);
    src_q[id].push_back(c); src_q[id].push_back(d);
    mdl_grp[id].push_back(a + b + c + d);
  endtask

  // Round-robin reference: serve every loaded group, lowest pending id at/above the pointer.
  task automatic predict();
    int pick;
    forever begin
      pick = -1;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (model_ptr + k) % NR;
        if (pick < 0 && mdl_grp[j].size() > 0) pick = j;
      end
      if (pick < 0) break;
      exp_id.push_back(pick);
      exp_sum.push_back(mdl_grp[pick].pop_front() % 1024);
      model_ptr = (pick + 1) % NR;
    end
  endtask

  task automatic wait_res(input int n);
    int t;
    t = 0;
    while (res_id_log.size() < n && t < 600) begin
      @(negedge clk); #3;
      t++;
    end
    repeat (4) begin @(negedge clk); #3; end
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    res_id_log.delete(); res_sum_log.delete(); beat_log.delete(); beat_cyc.delete();
    exp_id.delete(); exp_sum.delete();
    for (int i = 0; i < NR; i++) mdl_grp[i].delete();
    err_cnt = 0; model_ptr = 0;
    @(negedge clk); #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    release_reset();
  endtask

  task automatic test_reset();
    @(negedge clk); #3;
    checks++;
    if (req_ready !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b busy=%b expected 0000/0", req_ready, busy);
    end
    checks++;
    if (acc_valid_in !== 1'b0 || acc_data_in !== 8'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_acc: v=%b d=%0d err=%b expected 0", acc_valid_in, acc_data_in, err);
    end
    checks++;
    if (res_valid !== 1'b0 || res_data !== 10'd0 || res_id !== 2'd0) begin
      errors++; $display("FAIL reset_res: v=%b d=%0d id=%0d expected 0", res_valid, res_data, res_id);
    end
    release_reset();
  endtask

  task automatic test_single();
    int want[4];
    want = '{10, 20, 30, 40};
    fixed_lat = 2;
    load(2, 10, 20, 30, 40);
    predict();
    wait_res(1);
    checks++;
    if (beat_log.size() !== 4) begin
      errors++; $display("FAIL single_beats: got %0d beats expected 4", beat_log.size());
    end
    for (int i = 0; i < 4 && i < beat_log.size(); i++) begin
      checks++;
      if (beat_log[i] !== want[i]) begin
        errors++; $display("FAIL single_beat[%0d]: got %0d expected %0d", i, beat_log[i], want[i]);
      end
    end
    if (beat_cyc.size() >= 4) begin
      checks++;
      if (beat_cyc[3] - beat_cyc[0] !== 3) begin
        errors++; $display("FAIL single_b2b: span %0d expected 3", beat_cyc[3] - beat_cyc[0]);
      end
    end
    // Pointer should now sit at 3, so 3 beats 0 when both ask together.
    load(0, 1, 2, 3, 4);
    load(3, 9, 9, 9, 9);
    predict();
    wait_res(3);
    checks++;
    if (res_id_log.size() !== exp_id.size()) begin
      errors++; $display("FAIL single_count: got %0d results expected %0d", res_id_log.size(), exp_id.size());
    end
    for (int i = 0; i < exp_id.size() && i < res_id_log.size(); i++) begin
      checks++;
      if (res_id_log[i] !== exp_id[i] || res_sum_log[i] !== exp_sum[i]) begin
        errors++; $display("FAIL single_res[%0d]: got id=%0d sum=%0d expected id=%0d sum=%0d",
                           i, res_id_log[i], res_sum_log[i], exp_id[i], exp_sum[i]);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    fixed_lat = 0;
    for (int i = 0; i < NR; i++) load(i, 1, 1, 1, 1);
    load(0, 1, 1, 1, 1);
    predict();
    wait_res(5);
    checks++;
    if (res_id_log.size() !== 5) begin
      errors++; $display("FAIL fair_count: got %0d results expected 5", res_id_log.size());
    end
    for (int i = 0; i < exp_id.size() && i < res_id_log.size(); i++) begin
      checks++;
      if (res_id_log[i] !== exp_id[i] || res_sum_log[i] !== exp_sum[i]) begin
        errors++; $display("FAIL fair_res[%0d]: got id=%0d sum=%0d expected id=%0d sum=%0d",
                           i, res_id_log[i], res_sum_log[i], exp_id[i], exp_sum[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    load(0, 3, 3, 3, 3);
    predict();
    wait_res(1);
    ready_bad = 0;
    stall_at[1] = 2;
    stall_left[1] = 3;
    load(1, 7, 8, 9, 10);
    load(0, 1, 2, 3, 4);
    predict();
    wait_res(3);
    checks++;
    if (ready_bad !== 0 || stall_left[1] !== 0) begin
      errors++; $display("FAIL stall_ready0: got %0d bad cycles, %0d stall left, expected 0/0", ready_bad, stall_left[1]);
    end
    if (beat_cyc.size() >= 8) begin
      checks++;
      if (beat_log[4] !== 7 || beat_log[7] !== 10 || beat_cyc[6] - beat_cyc[5] !== 4) begin
        errors++; $display("FAIL stall_beats: got first=%0d last=%0d gap=%0d expected 7/10/4",
                           beat_log[4], beat_log[7], beat_cyc[6] - beat_cyc[5]);
      end
    end else begin
      checks++; errors++;
      $display("FAIL stall_beats: got %0d beats expected 12", beat_cyc.size());
    end
    for (int i = 0; i < exp_id.size(); i++) begin
      checks++;
      if (i >= res_id_log.size()) begin
        errors++; $display("FAIL stall_res[%0d]: got none expected id=%0d", i, exp_id[i]);
      end else if (res_id_log[i] !== exp_id[i] || res_sum_log[i] !== exp_sum[i]) begin
        errors++; $display("FAIL stall_res[%0d]: got id=%0d sum=%0d expected id=%0d sum=%0d",
                           i, res_id_log[i], res_sum_log[i], exp_id[i], exp_sum[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int k, e0, r0, t;
    k = model_ptr;
    e0 = err_cnt;
    r0 = res_id_log.size();
    acc_on = 0;
    load(k, 4, 4, 4, 4);
    mdl_grp[k].delete();
    t = 0;
    while (err_cnt == e0 && t < 100) begin @(negedge clk); #3; t++; end
    repeat (3) begin @(negedge clk); #3; end
    checks++;
    if (err_cnt !== e0 + 1) begin
      errors++; $display("FAIL timeout_err: got %0d pulses expected 1", err_cnt - e0);
    end
    checks++;
    if (err_cyc - entry_cyc !== WAIT_MAX || err_busy !== 0) begin
      errors++; $display("FAIL timeout_when: got delay=%0d busy=%0d expected %0d/0", err_cyc - entry_cyc, err_busy, WAIT_MAX);
    end
    checks++;
    if (res_id_log.size() !== r0) begin
      errors++; $display("FAIL timeout_nores: got %0d results expected %0d", res_id_log.size(), r0);
    end
    acc_on = 1;
    model_ptr = (k + 1) % NR;
    load(k, 5, 6, 7, 8);
    load((k + 1) % NR, 1, 1, 2, 2);
    predict();
    wait_res(r0 + 2);
    checks++;
    if (res_id_log.size() !== r0 + 2 || res_id_log[r0] !== (k + 1) % NR) begin
      errors++; $display("FAIL timeout_next: got %0d results expected next grant %0d", res_id_log.size() - r0, (k + 1) % NR);
    end
  endtask

  task automatic test_spurious();
    int e0, r0;
    e0 = err_cnt;
    r0 = res_id_log.size();
    spur = 1;
    repeat (4) begin @(negedge clk); #3; end
    checks++;
    if (err_cnt !== e0 + 1 || res_id_log.size() !== r0 || busy !== 1'b0) begin
      errors++; $display("FAIL spurious: got err=%0d res=%0d busy=%b expected 1/0/0", err_cnt - e0, res_id_log.size() - r0, busy);
    end
  endtask

  task automatic test_random();
    int total;
    rand_stall = 1;
    rand_lat = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) begin
        int n;
        n = int'($urandom_range(0, 2));
        for (int g = 0; g < n; g++)
          load(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      predict();
      wait_res(exp_id.size());
    end
    rand_stall = 0;
    rand_lat = 0;
    total = exp_id.size();
    checks++;
    if (res_id_log.size() !== total || multi_ready !== 0) begin
      errors++; $display("FAIL random_count: got %0d results, %0d multi-ready, expected %0d/0", res_id_log.size(), multi_ready, total);
    end
    for (int i = 0; i < total && i < res_id_log.size(); i++) begin
      checks++;
      if (res_id_log[i] !== exp_id[i] || res_sum_log[i] !== exp_sum[i]) begin
        errors++; $display("FAIL random_res[%0d]: got id=%0d sum=%0d expected id=%0d sum=%0d",
                           i, res_id_log[i], res_sum_log[i], exp_id[i], exp_sum[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b0, t;
    b0 = beat_log.size();
    load(0, 9, 9, 9, 9);
    t = 0;
    while (beat_log.size() < b0 + 2 && t < 50) begin @(negedge clk); #3; t++; end
    rst = 1'b1;
    #1;
    checks++;
    if (acc_valid_in !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got v=%b busy=%b ready=%b err=%b expected 0", acc_valid_in, busy, req_ready, err);
    end
    checks++;
    if (res_valid !== 1'b0 || res_data !== 10'd0 || res_id !== 2'd0 || acc_data_in !== 8'd0) begin
      errors++; $display("FAIL rstmid_data: got res=%0d id=%0d acc=%0d expected 0", res_data, res_id, acc_data_in);
    end
    release_reset();
    load(0, 5, 5, 5, 5);
    predict();
    wait_res(1);
    checks++;
    if (res_id_log.size() !== 1 || res_sum_log[0] !== exp_sum[0] || res_id_log[0] !== exp_id[0]) begin
      errors++; $display("FAIL rstmid_fresh: got %0d results expected 1 of id=%0d sum=%0d", res_id_log.size(), exp_id[0], exp_sum[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      hs_cnt[i] = 0; stall_at[i] = 0; stall_left[i] = 0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_timeout();
    test_spurious();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accu_sched.md
Name: accu_sched

Overview:
- Round-robin scheduler that shares one 4-beat accumulator datapath (8-bit samples in, 10-bit sum out, single-cycle result strobe) among NUM_REQ requesters.
- Grants one requester at a time for a complete group of GROUP beats.
- Forwards the granted beats to the accumulator, waits for its sum, and returns the sum tagged with the requester ID.
- Sits between the sample producers and the accumulator instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- GROUP, 4, beats per accumulation group; must match the accumulator's group length.
- WAIT_MAX, 15, maximum cycles in WAIT before timeout.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_data  in  8*NUM_REQ  per-requester sample; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  per-requester accept.
- acc_valid_in  out  1  beat strobe to the accumulator.
- acc_data_in  out  8  beat data to the accumulator.
- acc_valid_out  in  1  accumulator result strobe.
- acc_data_out  in  10  accumulator sum.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  10  captured sum.
- res_id  out  ID_W  requester that owns res_data.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on timeout or on a spurious acc_valid_out.

Behaviour:
- Reset (async, while rst=1):
  - State goes to IDLE; round-robin pointer = 0; beat counter = 0; wait counter = 0; grant = 0.
  - acc_valid_in=0, acc_data_in=0, res_valid=0, res_data=0, res_id=0, err=0.
  - req_ready=0 and busy=0 follow from the state.
- State machine: IDLE, GRANT, WAIT.
- IDLE:
  - If any req_valid is high, select the lowest index i at or above the pointer, wrapping modulo NUM_REQ.
  - Register grant=i and go to GRANT on the next edge.
  - Clear the beat counter.
- GRANT:
  - req_ready[grant]=1; all other req_ready are 0. req_ready is combinational from the state and grant registers.
  - A handshake is req_valid[grant] && req_ready[grant].
  - On each handshake, on the next edge: acc_valid_in=1, acc_data_in=req_data[grant], beat counter +1. Otherwise acc_valid_in=0.
  - acc_data_in holds its last value when acc_valid_in=0.
  - Grant is locked for the whole group. Stalls (req_valid[grant]=0) insert idle cycles; no other requester is served.
  - The handshake that makes the beat count equal GROUP moves the state to WAIT. req_ready drops in the same edge, so exactly GROUP beats are accepted.
- WAIT:
  - req_ready all 0. The wait counter increments every cycle, starting at 0 on entry.
  - On acc_valid_out=1:
    - Next edge: res_valid=1 for one cycle, res_data=acc_data_out, res_id=grant.
    - Pointer = (grant+1) mod NUM_REQ. Go to IDLE.
  - If the wait counter reaches WAIT_MAX without acc_valid_out:
    - err=1 for one cycle; go to IDLE; pointer advances as above; no res_valid.
  - acc_valid_out and timeout on the same cycle: the result wins, no err.
- acc_valid_out=1 in IDLE or GRANT: ignored for results, err pulses one cycle, state unchanged.
- res_data and res_id hold until the next result. res_valid is high for exactly one cycle.
- Minimum group turnaround with no stalls is GROUP+3 cycles plus accumulator latency: 1 cycle IDLE arbitration, GROUP beats, WAIT entry, result capture.
- A new arbitration can start the cycle after the return to IDLE. No overlap between groups.
- No arithmetic is done here. Sums are passed through untouched at 10 bits.
- Reset asserted mid-group abandons the group immediately. The accumulator must be reset by the same rst.

Test Plan:
- Single requester: req 2 sends 10,20,30,40 back-to-back -> acc_valid_in pulses 4 cycles carrying 10,20,30,40. With the accumulator model returning 100, expect res_valid one cycle, res_data=100, res_id=2, pointer=3.
- Fairness: all four req_valid held high, each sample = 1 -> grants in order 0,1,2,3,0. Each res_data=4. res_id sequence 0,1,2,3,0.
- Stall inside a group: req 1 drops req_valid for 3 cycles after beat 2 while req 0 stays valid -> req_ready[0] stays 0. Group completes with 4 beats from req 1 only; res_id=1.
- Timeout: accumulator model never strobes -> err pulses once WAIT_MAX cycles after WAIT entry, no res_valid, busy=0 next cycle, next grant goes to (grant+1).
- Spurious result: acc_valid_out pulsed in IDLE -> err pulses one cycle, res_valid stays 0, state stays IDLE.
- Reset mid-group: assert rst after beat 2 of 4 -> all outputs return to reset values asynchronously. After release, a fresh group from req 0 with 5,5,5,5 yields res_data=20.
